fifo_write_arbiter: RTL and testbench
=====================================

# fifo_write_arbiter

Round-robin write-port arbiter that lets several single-clock producers share the write side of one `Fifo` instance. Each producer presents data with a valid/ready handshake. The arbiter grants one producer at a time for a bounded burst and drives `wrdata`/`wrena` from a registered output stage that holds a word until the FIFO accepts it. It sits entirely in the FIFO's write clock domain, between the producers and the FIFO's `wrdata`, `wrena` and `full` pins.

## Interface
Parameters:
- `p_WIDTH`, default 8: data width; must equal the FIFO's `p_WIDTH`; ≥1.
- `p_PORTS`, default 4: number of requesters; ≥1.
- `p_BURST`, default 4: maximum words per grant; ≥1.

Ports:
- `clk`  in  1  clock; connects to the FIFO's `wrclk`.
- `rst`  in  1  asynchronous, active-high reset.
- `req_valid`  in  p_PORTS  per-port data valid.
- `req_data`  in  p_PORTS*p_WIDTH  per-port data; port i occupies bits [i*p_WIDTH +: p_WIDTH].
- `req_ready`  out  p_PORTS  per-port ready; a transfer occurs on a cycle where `req_valid[i]` and `req_ready[i]` are both high.
- `full`  in  1  FIFO full flag.
- `wrena`  out  1  FIFO write enable, registered.
- `wrdata`  out  p_WIDTH  FIFO write data, registered.
- `grant`  out  p_PORTS  one-hot current owner; all zero when idle.
- `busy`  out  1  high when any grant is held or `wrena` is high.

## Operation
- Output stage: `wrena`/`wrdata` form a one-word register.
  - A word leaves the stage on a clock edge where `wrena & ~full`.
  - `load_en = ~wrena | ~full`, so the stage can load when it is empty or draining this cycle.
  - On a transfer, `wrdata <= req_data[owner]` and `wrena <= 1`.
  - If `load_en` is high with no transfer, `wrena <= 0`.
  - If `load_en` is low, `wrena` and `wrdata` hold their values.
- Ready: `req_ready[i] = grant[i] & load_en`. This is combinational and does not depend on `req_valid`.
- State machine, IDLE and OWN:
  - **IDLE** (`grant`=0): if any `req_valid` bit is high, select the first set bit scanning from `ptr` upward modulo `p_PORTS`. Register its one-hot value into `grant`, clear `cnt`, and go to OWN.
  - **OWN**: `cnt` increments on each transfer. Return to IDLE, clearing `grant` and setting `ptr <= (owner+1) mod p_PORTS`, when either:
    - a transfer occurs with `cnt == p_BURST-1`, or
    - `req_valid[owner]` is low on any cycle, including during a stall.
- Arbitration happens only in IDLE. Every re-grant therefore costs one idle cycle.
- Width rules:
  - `cnt` is `$clog2(p_BURST+1)` bits.
  - `ptr` is `$clog2(p_PORTS)` bits, with a minimum of 1 bit.
  - `ptr` wraps from `p_PORTS-1` to 0.
- Reset values (asynchronous):
  - state = IDLE, `grant` = 0, `ptr` = 0, `cnt` = 0.
  - `wrena` = 0, `wrdata` = 0, `busy` = 0.
  - `req_ready` = 0 as a consequence of `grant` = 0.
- Reset mid-operation: any word held in the output stage is discarded and is never written. Producers must treat their un-acked data as not transferred.

## Timing
- Latency:
  - Cycle 0: `req_valid` rises with the arbiter in IDLE.
  - Cycle 1: `grant` is high and `req_ready` is high (if `load_en`); the transfer occurs at the end of cycle 1.
  - Cycle 2: `wrena` is high with that data.
- Throughput: with `full` low, the owner can transfer one word per cycle, giving back-to-back `wrena`.
  - `p_BURST` words are followed by one idle gap cycle before the next owner's first transfer.
- Stall: while `full & wrena`, all `req_ready` are low and `wrena`/`wrdata` stay stable. The word is written on the first edge where `full` is low.
- Simultaneous requests: only the round-robin winner is granted. Other ports see `req_ready`=0 and must hold their data.
- `p_PORTS`=1: `ptr` stays at 0, and the grant releases and re-acquires every `p_BURST` words.
- `p_BURST`=1: release after every transfer, which alternates transfer and idle cycles per grant.

## Test plan
- **Reset values**: assert `rst` asynchronously mid-cycle → `wrena`=0, `wrdata`=0, `grant`=0, `busy`=0 immediately, without waiting for a clock edge.
- **Single port**: `p_PORTS`=4, `p_BURST`=4, `full`=0. Port 2 streams 0x10..0x17.
  - `grant`=4'b0100 from cycle 1.
  - `wrena` carries 0x10..0x13 in cycles 2–5.
  - One gap cycle follows, then 0x14..0x17.
- **Round-robin**: all four ports are held valid from reset.
  - Grant order is 0,1,2,3,0.
  - Each grant lasts exactly 4 transfers.
  - The FIFO receives 16 words per 20 cycles.
- **Full stall**: assert `full` while `wrena`=1 with `wrdata`=0xA5 for 5 cycles.
  - `wrdata` holds 0xA5 and all `req_ready` are 0.
  - After `full` drops, 0xA5 is written exactly once and the stream resumes without loss or duplication.
- **Early release**: port 1 drops `req_valid` after 2 of 4 words while port 3 is valid.
  - `grant` goes to 0 on the next cycle, then to 4'b1000.
  - `ptr` becomes 2.
- **Reset mid-burst**: assert `rst` while `wrena`=1 holding 0x5C and `full`=1.
  - After release, 0x5C is never written.
  - Arbitration restarts at port 0.

Source files
------------

// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among several producers.
// Bounded bursts per grant; a one-word output register drives wrena/wrdata.
module fifo_write_arbiter #(
    parameter int p_WIDTH = 8,
    parameter int p_PORTS = 4,
    parameter int p_BURST = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [p_PORTS-1:0]         req_valid,
    input  logic [p_PORTS*p_WIDTH-1:0] req_data,
    output logic [p_PORTS-1:0]         req_ready,
    input  logic                       full,
    output logic                       wrena,
    output logic [p_WIDTH-1:0]         wrdata,
    output logic [p_PORTS-1:0]         grant,
    output logic                       busy
);

    localparam int PW = (p_PORTS > 1) ? $clog2(p_PORTS) : 1;
    localparam int CW = $clog2(p_BURST + 1);
    localparam logic [CW-1:0] LAST = CW'(p_BURST - 1);
    localparam logic [PW-1:0] TOP  = PW'(p_PORTS - 1);

    typedef enum logic {
        S_IDLE,
        S_OWN
    } state_t;

    state_t             state;
    state_t             state_d;
    logic [p_PORTS-1:0] grant_d;
    logic [PW-1:0]      ptr;
    logic [PW-1:0]      ptr_d;
    logic [PW-1:0]      owner;
    logic [PW-1:0]      owner_d;
    logic [PW-1:0]      owner_nxt;
    logic [PW-1:0]      pick;
    logic [PW-1:0]      cand;
    logic [CW-1:0]      cnt;
    logic [CW-1:0]      cnt_d;
    logic               found;
    logic               load_en;
    logic               xfer;
    logic               owner_valid;
    logic [p_WIDTH-1:0] owner_data;

    // The stage can accept a word when empty or when its word drains now.
    assign load_en   = ~wrena | ~full;
    assign req_ready = grant & {p_PORTS{load_en}};
    assign xfer      = owner_valid & load_en;
    assign busy      = (|grant) | wrena;
    assign owner_nxt = (owner == TOP) ? '0 : owner + 1'b1;

    // Round-robin search: first valid port at or above ptr, wrapping.
    always_comb begin
        pick  = '0;
        cand  = '0;
        found = 1'b0;
        for (int k = 0; k < p_PORTS; k++) begin
            cand = PW'((int'(ptr) + k) % p_PORTS);
            if (!found && req_valid[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    // Select the current owner's valid and data through the one-hot grant.
    always_comb begin
        owner_valid = 1'b0;
        owner_data  = '0;
        for (int i = 0; i < p_PORTS; i++) begin
            if (grant[i]) begin
                owner_valid = req_valid[i];
                owner_data  = req_data[i*p_WIDTH +: p_WIDTH];
            end
        end
    end

    // Next-state: grant in IDLE, count and release in OWN.
    always_comb begin
        state_d = state;
        grant_d = grant;
        ptr_d   = ptr;
        owner_d = owner;
        cnt_d   = cnt;
        unique case (state)
            S_IDLE: begin
                if (found) begin
                    state_d       = S_OWN;
                    grant_d       = '0;
                    grant_d[pick] = 1'b1;
                    owner_d       = pick;
                    cnt_d         = '0;
                end
            end
            S_OWN: begin
                if (xfer) begin
                    cnt_d = cnt + 1'b1;
                end
                if (!owner_valid || (xfer && cnt == LAST)) begin
                    state_d = S_IDLE;
                    grant_d = '0;
                    ptr_d   = owner_nxt;
                end
            end
        endcase
    end

    // Arbiter state, grant, pointer and burst counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            grant <= '0;
            ptr   <= '0;
            owner <= '0;
            cnt   <= '0;
        end else begin
            state <= state_d;
            grant <= grant_d;
            ptr   <= ptr_d;
            owner <= owner_d;
            cnt   <= cnt_d;
        end
    end

    // One-word output stage; holds its word while the FIFO is full.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wrena  <= 1'b0;
            wrdata <= '0;
        end else if (load_en) begin
            wrena <= xfer;
            if (xfer) begin
                wrdata <= owner_data;
            end
        end
    end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Bench for fifo_write_arbiter: directed scenarios plus random traffic,
// every cycle compared against a queue-based behavioural model.
module tb_fifo_write_arbiter;

    localparam int W = 8;
    localparam int P = 4;
    localparam int B = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [P-1:0] req_valid = '0;
    logic [P*W-1:0] req_data = '0;
    logic [P-1:0] req_ready;
    logic         full = 1'b0;
    logic         wrena;
    logic [W-1:0] wrdata;
    logic [P-1:0] grant;
    logic         busy;

    fifo_write_arbiter #(
        .p_WIDTH(W),
        .p_PORTS(P),
        .p_BURST(B)
    ) dut (
        .clk(clk),
        .rst(rst),
        .req_valid(req_valid),
        .req_data(req_data),
        .req_ready(req_ready),
        .full(full),
        .wrena(wrena),
        .wrdata(wrdata),
        .grant(grant),
        .busy(busy)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // producers: per-port pending words and a willingness flag
    logic [W-1:0] q[P][$];
    bit   [P-1:0] want = '0;

    // behavioural model: owner (-1 idle), words this grant, pointer,
    // output register contents, and number of words written so far
    int           m_own = -1;
    int           m_taken = 0;
    int           m_ptr = 0;
    bit           m_v = 1'b0;
    logic [W-1:0] m_d = '0;
    int           m_writes = 0;

    logic [W-1:0] dut_log[$];

    logic [P-1:0] s_grant;
    logic [P-1:0] s_ready;
    logic         s_wrena;
    logic [W-1:0] s_wrdata;
    logic         s_busy;
    logic         s_wr;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic apply_inputs();
        for (int i = 0; i < P; i++) begin
            req_valid[i] = want[i] && (q[i].size() > 0);
            req_data[i*W +: W] = (q[i].size() > 0) ? q[i][0] : '0;
        end
    endtask

    task automatic model_reset();
        m_own = -1;
        m_taken = 0;
        m_ptr = 0;
        m_v = 1'b0;
        m_d = '0;
        m_writes = 0;
        dut_log.delete();
    endtask

    // Called at posedge+1; compares mid-cycle, advances model, waits one edge.
    task automatic cycle();
        logic [P-1:0] e_grant;
        logic [P-1:0] e_rdy;
        bit ld;
        bit x;
        int nxt;
        apply_inputs();
        #3;
        s_grant  = grant;
        s_ready  = req_ready;
        s_wrena  = wrena;
        s_wrdata = wrdata;
        s_busy   = busy;
        s_wr     = wrena && !full;
        if (s_wr) dut_log.push_back(wrdata);

        ld = !m_v || !full;
        e_grant = '0;
        e_rdy = '0;
        if (m_own >= 0) begin
            e_grant[m_own] = 1'b1;
            if (ld) e_rdy[m_own] = 1'b1;
        end
        chk("grant", {28'd0, s_grant}, {28'd0, e_grant});
        chk("req_ready", {28'd0, s_ready}, {28'd0, e_rdy});
        chk("wrena", {31'd0, s_wrena}, {31'd0, m_v});
        chk("wrdata", {24'd0, s_wrdata}, {24'd0, m_d});
        chk("busy", {31'd0, s_busy}, {31'd0, (m_own >= 0) || m_v});

        if (m_v && !full) m_writes++;
        x = 1'b0;
        nxt = m_own;
        if (m_own < 0) begin
            for (int k = P - 1; k >= 0; k--) begin
                if (req_valid[(m_ptr + k) % P]) nxt = (m_ptr + k) % P;
            end
            m_taken = 0;
        end else begin
            x = req_valid[m_own] && ld;
            if (x) begin
                m_d = q[m_own].pop_front();
                m_taken++;
            end
            if (!req_valid[m_own] || (x && m_taken == B)) begin
                m_ptr = (m_own + 1) % P;
                nxt = -1;
            end
        end
        if (ld) m_v = x;
        m_own = nxt;
        @(posedge clk);
        #1;
    endtask

    // Asserts reset between edges and checks outputs clear at once.
    task automatic do_reset();
        rst = 1'b1;
        #1;
        chk("rst_wrena", {31'd0, wrena}, 32'd0);
        chk("rst_wrdata", {24'd0, wrdata}, 32'd0);
        chk("rst_grant", {28'd0, grant}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_ready", {28'd0, req_ready}, 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic clear_ports();
        for (int i = 0; i < P; i++) q[i].delete();
        want = '0;
        full = 1'b0;
        apply_inputs();
    endtask

    initial begin
        logic [P-1:0] order[$];
        logic [P-1:0] last_g;
        int nwr;
        int n5c;

        #2;
        do_reset();

        // single port: port 2 streams 0x10..0x17
        for (int k = 0; k < 8; k++) q[2].push_back(8'(8'h10 + k));
        want = 4'b0100;
        for (int c = 0; c < 13; c++) begin
            cycle();
            if (c == 1) chk("sp_grant", {28'd0, s_grant}, 32'h4);
            if (c >= 2 && c <= 5) begin
                chk("sp_wrena", {31'd0, s_wrena}, 32'd1);
                chk("sp_data", {24'd0, s_wrdata}, 32'h10 + c - 2);
            end
            if (c == 6) chk("sp_gap", {31'd0, s_wrena}, 32'd0);
            if (c == 7) chk("sp_data2", {24'd0, s_wrdata}, 32'h14);
        end

        // round-robin: all ports valid from reset
        clear_ports();
        do_reset();
        for (int i = 0; i < P; i++)
            for (int k = 0; k < 12; k++) q[i].push_back(8'(i * 16 + k));
        want = 4'b1111;
        last_g = '0;
        nwr = 0;
        for (int c = 0; c < 26; c++) begin
            cycle();
            if (s_grant != '0 && s_grant != last_g) order.push_back(s_grant);
            last_g = s_grant;
            if (c >= 2 && c <= 21 && s_wr) nwr++;
        end
        chk("rr_n_grants", order.size() >= 5 ? 32'd1 : 32'd0, 32'd1);
        if (order.size() >= 5) begin
            chk("rr_g0", {28'd0, order[0]}, 32'h1);
            chk("rr_g1", {28'd0, order[1]}, 32'h2);
            chk("rr_g2", {28'd0, order[2]}, 32'h4);
            chk("rr_g3", {28'd0, order[3]}, 32'h8);
            chk("rr_g4", {28'd0, order[4]}, 32'h1);
        end
        chk("rr_words_in_20", nwr, 32'd16);

        // full stall holding 0xA5
        clear_ports();
        do_reset();
        for (int k = 0; k < 8; k++) q[0].push_back(8'(8'hA5 + k));
        want = 4'b0001;
        for (int c = 0; c < 22; c++) begin
            full = (c >= 2 && c <= 6);
            cycle();
            if (c >= 2 && c <= 6) begin
                chk("st_hold", {24'd0, s_wrdata}, 32'hA5);
                chk("st_wrena", {31'd0, s_wrena}, 32'd1);
                chk("st_ready", {28'd0, s_ready}, 32'd0);
            end
        end
        chk("st_count", dut_log.size(), 32'd8);
        for (int k = 0; k < 8 && k < dut_log.size(); k++)
            chk("st_seq", {24'd0, dut_log[k]}, 32'hA5 + k);

        // early release: port 1 stops after 2 words, port 3 waiting
        clear_ports();
        do_reset();
        q[1].push_back(8'h21);
        q[1].push_back(8'h22);
        for (int k = 0; k < 4; k++) q[3].push_back(8'(8'h31 + k));
        want = 4'b1010;
        for (int c = 0; c < 12; c++) begin
            cycle();
            if (c == 1) chk("er_grant1", {28'd0, s_grant}, 32'h2);
            if (c == 4) begin
                chk("er_idle", {28'd0, s_grant}, 32'h0);
                chk("er_ptr", {30'd0, dut.ptr}, 32'd2);
            end
            if (c == 5) chk("er_grant3", {28'd0, s_grant}, 32'h8);
        end

        // reset while 0x5C sits in the stalled output register
        clear_ports();
        do_reset();
        for (int k = 0; k < 4; k++) q[1].push_back(8'(8'h5C + k));
        want = 4'b0010;
        for (int c = 0; c < 3; c++) begin
            full = (c == 2);
            cycle();
            if (c == 2) begin
                chk("rb_wrena", {31'd0, s_wrena}, 32'd1);
                chk("rb_held", {24'd0, s_wrdata}, 32'h5C);
            end
        end
        #2;
        do_reset();
        full = 1'b0;
        for (int i = 0; i < P; i++)
            if (i != 1)
                for (int k = 0; k < 6; k++) q[i].push_back(8'(i * 16 + k));
        want = 4'b1111;
        for (int c = 0; c < 30; c++) begin
            cycle();
            if (c == 1) chk("rb_restart", {28'd0, s_grant}, 32'h1);
        end
        n5c = 0;
        foreach (dut_log[k]) if (dut_log[k] == 8'h5C) n5c++;
        chk("rb_no_5c", n5c, 32'd0);

        // random traffic with random back-pressure
        clear_ports();
        do_reset();
        for (int c = 0; c < 2500; c++) begin
            for (int i = 0; i < P; i++) begin
                while (q[i].size() < 3) q[i].push_back(8'($urandom));
                want[i] = ($urandom_range(0, 9) < 8);
            end
            full = ($urandom_range(0, 9) < 3);
            cycle();
        end
        chk("rnd_writes", dut_log.size(), m_writes);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
